// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SCNT_W     = $clog2(OVERSAMPLE);
    localparam int START_MID  = 7;
    localparam int BIT_END    = 15;

endpackage

// File: rtl/uart_tick_gen.sv
// Phase-accumulator tick generator: one-cycle tick on each accumulator carry.
module uart_tick_gen #(
    parameter int ACC_SIZE = 12,
    parameter int FCW      = 59
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [ACC_SIZE:0] FCW_EXT = (ACC_SIZE + 1)'(FCW);

    logic [ACC_SIZE:0] r_acc;

    // The carry is kept as a registered top bit and dropped on the next add.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (clr_i) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[ACC_SIZE-1:0]} + FCW_EXT;
        end
    end

    assign tick_o = r_acc[ACC_SIZE];

endmodule

// File: rtl/uart_rx_acc.sv
// 16x oversampling UART receiver with valid/ready output and per-byte error flags.
module uart_rx_acc
    import uart_pkg::*;
#(
    parameter int ACC_SIZE   = 12,
    parameter int FCW        = 59,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(START_MID);
    localparam logic [SCNT_W-1:0] SCNT_END  = SCNT_W'(BIT_END);
    localparam logic [3:0]        LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic              ODD_SEL   = 1'(PARITY_ODD);
    localparam logic              PAR_ON    = (PARITY_EN != 0);

    logic [1:0]           r_sync;
    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 w_tick;
    logic                 w_clr;
    logic                 w_cnt_clr;
    logic                 w_shift;
    logic                 w_par_smp;
    logic                 w_stop_smp;
    logic [SCNT_W-1:0]    r_scnt;
    logic [3:0]           r_bcnt;
    logic [DATA_BITS-1:0] r_sreg;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_pe;
    logic                 r_fe;
    logic                 r_ovr;

    uart_tick_gen #(
        .ACC_SIZE (ACC_SIZE),
        .FCW      (FCW)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_clr       = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                // A start bit that is high again at its mid-point was a glitch.
                if (w_tick && r_scnt == SCNT_MID) begin
                    if (!w_rx_s) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_tick && r_scnt == SCNT_END) begin
                    w_shift = 1'b1;
                    if (r_bcnt == LAST_BIT) begin
                        w_state_nxt = PAR_ON ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_tick && r_scnt == SCNT_END) begin
                    w_par_smp   = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick && r_scnt == SCNT_END) begin
                    w_stop_smp  = 1'b1;
                    w_state_nxt = w_rx_s ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scnt    <= '0;
            r_bcnt    <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_scnt <= '0;
            end else if (w_tick) begin
                r_scnt <= r_scnt + 1'b1;
            end
            if (w_cnt_clr) begin
                r_bcnt <= '0;
            end else if (w_shift) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (w_cnt_clr) begin
                r_par_err <= 1'b0;
            end else if (w_par_smp) begin
                r_par_err <= ((^r_sreg) ^ w_rx_s) != ODD_SEL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_shift) begin
            r_sreg <= {w_rx_s, r_sreg[DATA_BITS-1:1]};
        end
    end

    // A load and an accept in the same cycle keep valid high with the new byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_stop_smp && (!r_valid || ready_i)) begin
                r_data  <= r_sreg;
                r_valid <= 1'b1;
                r_pe    <= PAR_ON && r_par_err;
                r_fe    <= !w_rx_s;
            end else begin
                if (w_stop_smp) begin
                    r_ovr <= 1'b1;
                end
                if (r_valid && ready_i) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign parity_err_o = r_pe;
    assign frame_err_o  = r_fe;
    assign overrun_o    = r_ovr;

endmodule

// File: tb/tb_uart_rx_acc.sv
// Directed bench for uart_rx_acc: 8N1 instance and an 8E1 instance, 32 clk per bit.
module tb_uart_rx_acc;

    localparam int BIT_CLK = 32;
    localparam int LAT_VLD = 308;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rxp = 1'b1;
    logic       ready = 1'b1;
    logic       ready_p = 1'b1;
    logic [7:0] data;
    logic [7:0] data_p;
    logic       valid, pe, fe, ovr;
    logic       valid_p, pe_p, fe_p, ovr_p;

    always #5 clk = ~clk;

    uart_rx_acc #(
        .ACC_SIZE(8), .FCW(128), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_o(data), .valid_o(valid),
        .ready_i(ready), .parity_err_o(pe), .frame_err_o(fe), .overrun_o(ovr)
    );

    uart_rx_acc #(
        .ACC_SIZE(8), .FCW(128), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rxp), .data_o(data_p), .valid_o(valid_p),
        .ready_i(ready_p), .parity_err_o(pe_p), .frame_err_o(fe_p), .overrun_o(ovr_p)
    );

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;

    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         vld_cyc = 0;
    int         acc_cnt = 0;
    int         ovr_cnt = 0;
    logic       vld_prev = 1'b0;
    logic [7:0] last_data = '0;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;
    int         p_acc = 0;
    logic [7:0] p_data = '0;
    logic       p_pe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) vld_cyc++;
        if (valid && !vld_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        vld_prev = valid;
        if (valid && ready) begin
            acc_cnt++;
            last_data = data;
            last_pe   = pe;
            last_fe   = fe;
        end
        if (ovr) ovr_cnt++;
        if (valid_p && ready_p) begin
            p_acc++;
            p_data = data_p;
            p_pe   = pe_p;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_bit(input bit par_line, input bit b);
        if (par_line) rxp = b;
        else rx = b;
        step(BIT_CLK);
    endtask

    task automatic send_frame(input bit par_line, input logic [7:0] d,
                              input bit with_par, input bit par_bit, input bit stop_bit);
        t_start = cyc;
        put_bit(par_line, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(par_line, d[i]);
        if (with_par) put_bit(par_line, par_bit);
        put_bit(par_line, stop_bit);
    endtask

    int r0, a0, o0, v0, pa0;
    logic [7:0] d7e;

    initial begin
        step(3);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_perr", 32'(pe), 32'd0);
        check_eq("rst_ferr", 32'(fe), 32'd0);
        check_eq("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        step(4);

        // 0xA5, 8N1, ready high
        r0 = rise_cnt; a0 = acc_cnt; v0 = vld_cyc;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        step(16);
        check_eq("a5_rises", 32'(rise_cnt - r0), 32'd1);
        check_eq("a5_accepts", 32'(acc_cnt - a0), 32'd1);
        check_eq("a5_data", 32'(last_data), 32'hA5);
        check_eq("a5_perr", 32'(last_pe), 32'd0);
        check_eq("a5_ferr", 32'(last_fe), 32'd0);
        check_eq("a5_vld_cycles", 32'(vld_cyc - v0), 32'd1);
        check_eq("a5_latency", 32'(rise_cyc - t_start), 32'(LAT_VLD));

        // 10-clk glitch on idle line
        r0 = rise_cnt;
        rx = 1'b0;
        step(10);
        rx = 1'b1;
        step(12 * BIT_CLK);
        check_eq("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
        check_eq("glitch_valid_lvl", 32'(valid), 32'd0);

        // Even parity, 0x03: parity bit 1 is wrong, 0 is right
        pa0 = p_acc;
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        step(16);
        check_eq("par1_accepts", 32'(p_acc - pa0), 32'd1);
        check_eq("par1_data", 32'(p_data), 32'h03);
        check_eq("par1_perr", 32'(p_pe), 32'd1);
        pa0 = p_acc;
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        step(16);
        check_eq("par0_accepts", 32'(p_acc - pa0), 32'd1);
        check_eq("par0_perr", 32'(p_pe), 32'd0);

        // 0x55 with a low stop bit, then break for 20 bit times
        r0 = rise_cnt; a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        step(20 * BIT_CLK);
        rx = 1'b1;
        step(2 * BIT_CLK);
        check_eq("brk_rises", 32'(rise_cnt - r0), 32'd1);
        check_eq("brk_accepts", 32'(acc_cnt - a0), 32'd1);
        check_eq("brk_data", 32'(last_data), 32'h55);
        check_eq("brk_ferr", 32'(last_fe), 32'd1);
        check_eq("brk_ovr", 32'(ovr_cnt - o0), 32'd0);

        r0 = rise_cnt;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        step(16);
        check_eq("3c_rises", 32'(rise_cnt - r0), 32'd1);
        check_eq("3c_data", 32'(last_data), 32'h3C);
        check_eq("3c_ferr", 32'(last_fe), 32'd0);

        // Overrun: consumer stalled over two frames
        ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        step(BIT_CLK);
        check_eq("ovr_data_held", 32'(data), 32'h11);
        check_eq("ovr_valid_held", 32'(valid), 32'd1);
        check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check_eq("ovr_no_accept", 32'(acc_cnt - a0), 32'd0);
        ready = 1'b1;
        step(1);
        check_eq("ovr_valid_drop", 32'(valid), 32'd0);
        check_eq("ovr_accepts", 32'(acc_cnt - a0), 32'd1);
        check_eq("ovr_acc_data", 32'(last_data), 32'h11);
        step(4);

        // Reset in the middle of 0x7E data, then 0x81
        r0 = rise_cnt;
        d7e = 8'h7E;
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b0, d7e[i]);
        rst_n = 1'b0;
        rx = 1'b1;
        step(3);
        check_eq("mrst_valid", 32'(valid), 32'd0);
        check_eq("mrst_data", 32'(data), 32'd0);
        check_eq("mrst_perr", 32'(pe), 32'd0);
        check_eq("mrst_ferr", 32'(fe), 32'd0);
        check_eq("mrst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        step(2 * BIT_CLK);
        check_eq("mrst_no_byte", 32'(rise_cnt - r0), 32'd0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLK);
        check_eq("81_rises", 32'(rise_cnt - r0), 32'd1);
        check_eq("81_data", 32'(last_data), 32'h81);
        check_eq("81_ferr", 32'(last_fe), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
